mem_responder: RTL

//   Memory-side responder for the core's memory bus: the target end of the
//   r_en/w_en/addr/w_data/r_data interface that the memory controller drives.

---
 rtl/mem_responder.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : mem_responder
// Purpose  : Memory-side target of the core memory bus. Holds a
//            2**ADDR_BITS-word RAM plus a separately stored interrupt word.
//            Reads return through a READ_LAT-deep pipeline with a valid
//            strobe. Illegal requests raise a one-cycle error pulse.
// Ports    : clk          - clock, all logic on the rising edge
//            rst_n        - synchronous active-low reset
//            i_mem_r_en   - read request, sampled every cycle
//            i_mem_w_en   - write request, sampled every cycle
//            i_mem_addr   - word address (upper bits must be zero)
//            i_mem_w_data - write data
//            o_mem_r_data - read data, held between strobes
//            o_r_valid    - one-cycle strobe, read data returned this cycle
//            o_interrupt  - current interrupt word
//            o_err        - one-cycle pulse, illegal request at last edge
// Revision : 1.0 - initial release
// ============================================================================

`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

module mem_responder #(
    parameter int ADDR_BITS = 8,
    parameter int READ_LAT  = 2,
    parameter int INT_ADDR  = (2**ADDR_BITS) - 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_mem_r_en,
    input  logic                   i_mem_w_en,
    input  logic [`DATA_WIDTH-1:0] i_mem_addr,
    input  logic [`DATA_WIDTH-1:0] i_mem_w_data,
    output logic [`DATA_WIDTH-1:0] o_mem_r_data,
    output logic                   o_r_valid,
    output logic [`DATA_WIDTH-1:0] o_interrupt,
    output logic                   o_err
);

    localparam int                  c_data_w  = `DATA_WIDTH;
    localparam int                  c_depth   = 2**ADDR_BITS;
    localparam logic [ADDR_BITS-1:0] c_int_idx = ADDR_BITS'(INT_ADDR);

    // Parameter sanity: refuse to elaborate an unsupported configuration.
    if (READ_LAT < 1 || READ_LAT > 4) begin : g_bad_read_lat
        $error("mem_responder: READ_LAT must be in 1..4");
    end
    if (ADDR_BITS < 1 || ADDR_BITS >= c_data_w) begin : g_bad_addr_bits
        $error("mem_responder: ADDR_BITS must be in 1..DATA_WIDTH-1");
    end
    if (INT_ADDR < 0 || INT_ADDR >= c_depth) begin : g_bad_int_addr
        $error("mem_responder: INT_ADDR must be a valid word index");
    end

    logic [c_data_w-1:0]  r_mem [c_depth];
    logic [c_data_w-1:0]  r_interrupt;
    logic                 r_err;

    logic [ADDR_BITS-1:0] w_index;
    logic                 w_out_of_range;
    logic                 w_is_int;
    logic                 w_wr_ok;
    logic                 w_rd_accept;
    logic [c_data_w-1:0]  w_rd_data;
    logic                 w_err;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    always_comb begin
        w_index        = i_mem_addr[ADDR_BITS-1:0];
        w_out_of_range = |i_mem_addr[c_data_w-1:ADDR_BITS];
        w_is_int       = (w_index == c_int_idx);
        w_wr_ok        = i_mem_w_en & ~w_out_of_range;
        // A simultaneous write wins; the read is dropped and flagged.
        w_rd_accept    = i_mem_r_en & ~i_mem_w_en;
        // Data is sampled at the request edge, so reads already in flight
        // keep their value even if the word is rewritten afterwards.
        if (w_out_of_range) begin
            w_rd_data = '0;
        end else if (w_is_int) begin
            w_rd_data = r_interrupt;
        end else begin
            w_rd_data = r_mem[w_index];
        end
        w_err = (i_mem_r_en & i_mem_w_en) |
                ((i_mem_r_en | i_mem_w_en) & w_out_of_range);
    end

    // ------------------------------------------------------------------
    // Storage. The RAM has no reset so it maps onto block memory; writes
    // are suppressed while reset is asserted.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst_n && w_wr_ok && !w_is_int) begin
            r_mem[w_index] <= i_mem_w_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_interrupt <= '0;
            r_err       <= 1'b0;
        end else begin
            if (w_wr_ok && w_is_int) begin
                r_interrupt <= i_mem_w_data;
            end
            r_err <= w_err;
        end
    end

    // ------------------------------------------------------------------
    // Read pipeline. Stage 0 captures at the request edge, so the last
    // stage is visible READ_LAT cycles after the request. Each stage only
    // loads data alongside a valid, which makes the last stage hold the
    // most recently returned word between strobes.
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < READ_LAT; gi++) begin : g_stage
        logic                w_in_valid;
        logic [c_data_w-1:0] w_in_data;
        logic                r_valid;
        logic [c_data_w-1:0] r_data;

        if (gi == 0) begin : g_head
            assign w_in_valid = w_rd_accept;
            assign w_in_data  = w_rd_data;
        end else begin : g_body
            assign w_in_valid = g_stage[gi-1].r_valid;
            assign w_in_data  = g_stage[gi-1].r_data;
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_valid <= 1'b0;
                r_data  <= '0;
            end else begin
                r_valid <= w_in_valid;
                if (w_in_valid) begin
                    r_data <= w_in_data;
                end
            end
        end
    end

    assign o_r_valid    = g_stage[READ_LAT-1].r_valid;
    assign o_mem_r_data = g_stage[READ_LAT-1].r_data;
    assign o_interrupt  = r_interrupt;
    assign o_err        = r_err;

endmodule

`default_nettype wire
